// File: rtl/vec_alu_seq.sv
// vec_alu_seq: multi-cycle masked vector ALU with per-lane NZCV flags, PAR lanes per beat.
// Define VEC_REDUCE_EN to add the red_sum output (sum of unmasked lane results).
module vec_alu_seq #(
  parameter int WIDTH = 32,
  parameter int LANES = 8,
  parameter int PAR   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             op,
  input  logic [LANES-1:0]       mask,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic [4*LANES-1:0]     lane_flags,
  output logic                   z_all
`ifdef VEC_REDUCE_EN
  ,
  output logic [WIDTH-1:0]       red_sum
`endif
);
  localparam int K  = LANES / PAR;
  localparam int BW = (K > 1) ? $clog2(K) : 1;

  if (LANES % PAR != 0) begin : g_bad_par
    $error("vec_alu_seq: LANES must be a multiple of PAR");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("vec_alu_seq: WIDTH must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                          state_q, state_d;
  logic [BW-1:0]                   beat_q, beat_d;
  logic [2:0]                      op_q, op_d;
  logic [K-1:0][PAR-1:0]           mask_q, mask_d;
  logic [K-1:0][PAR*WIDTH-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic [K-1:0][4*PAR-1:0]         flags_q, flags_d;
  logic                            z_all_q, z_all_d;
  logic [WIDTH+3:0]                lr;
`ifdef VEC_REDUCE_EN
  logic [WIDTH-1:0]                acc_q, acc_d;
  assign red_sum = acc_q;
`endif

  // Returns {N,Z,C,V,result}; SUB is a + ~b + 1 so the carry-out is NOT borrow.
  function automatic logic [WIDTH+3:0] lane_op(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] r;
    logic             c, v;
    s = (o == 3'b001) ? {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1) : {1'b0, x} + {1'b0, y};
    c = 1'b0;
    v = 1'b0;
    case (o)
      3'b000: begin
        r = s[WIDTH-1:0];
        c = s[WIDTH];
        v = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      3'b001: begin
        r = s[WIDTH-1:0];
        c = s[WIDTH];
        v = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      3'b010:  r = x & y;
      3'b011:  r = x | y;
      3'b100:  r = x ^ y;
      3'b101:  r = ($signed(x) < $signed(y)) ? x : y;
      3'b110:  r = ($signed(x) > $signed(y)) ? x : y;
      default: r = y;
    endcase
    return {r[WIDTH-1], r == '0, c, v, r};
  endfunction

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign result     = res_q;
  assign lane_flags = flags_q;
  assign z_all      = z_all_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    op_d    = op_q;
    mask_d  = mask_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flags_d = flags_q;
    z_all_d = z_all_q;
    lr      = '0;
`ifdef VEC_REDUCE_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = BUSY;
        beat_d  = '0;
        op_d    = op;
        mask_d  = mask;
        a_d     = a;
        b_d     = b;
`ifdef VEC_REDUCE_EN
        acc_d   = '0;
`endif
      end
      BUSY: begin
        for (int p = 0; p < PAR; p++) begin
          lr = mask_q[beat_q][p] ? lane_op(op_q, a_q[beat_q][p*WIDTH +: WIDTH], b_q[beat_q][p*WIDTH +: WIDTH])
                                 : {4'b0000, a_q[beat_q][p*WIDTH +: WIDTH]};
          res_d[beat_q][p*WIDTH +: WIDTH] = lr[WIDTH-1:0];
          flags_d[beat_q][4*p +: 4]       = lr[WIDTH+3:WIDTH];
`ifdef VEC_REDUCE_EN
          acc_d = acc_d + (mask_q[beat_q][p] ? lr[WIDTH-1:0] : '0);
`endif
        end
        beat_d = beat_q + 1'b1;
        if (beat_q == BW'(K-1)) begin
          state_d = DONE;
          beat_d  = '0;
          z_all_d = (res_d == '0);
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      op_q    <= '0;
      mask_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
      z_all_q <= 1'b1;
`ifdef VEC_REDUCE_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      z_all_q <= z_all_d;
`ifdef VEC_REDUCE_EN
      acc_q   <= acc_d;
`endif
    end
  end
endmodule

// File: tb/tb_vec_alu_seq.sv
// tb_vec_alu_seq: directed and random checks of vec_alu_seq against a lane-arithmetic reference model.
module tb_vec_alu_seq;
  localparam int W = 32, L = 8, P = 2, K = L / P, VW = W * L;
  localparam longint SMAX = 64'sd2147483647, SMIN = -64'sd2147483648;

  logic          clk = 0, reset = 0, in_valid = 0, out_ready = 0;
  logic          in_ready, out_valid, z_all;
  logic [2:0]    op = 0;
  logic [L-1:0]  mask = 0;
  logic [VW-1:0] a = '0, b = '0, result;
  logic [4*L-1:0] lane_flags;
  logic [W-1:0]  red_sum_w;
`ifdef VEC_REDUCE_EN
  logic [W-1:0]  red_sum;
  assign red_sum_w = red_sum;
`else
  assign red_sum_w = '0;
`endif

  int n_cmp = 0, n_bad = 0;
  logic [VW-1:0]  er, va, vb;
  logic [4*L-1:0] ef;
  logic           ez;
  logic [W-1:0]   es;

  always #5 clk = ~clk;

  vec_alu_seq #(.WIDTH(W), .LANES(L), .PAR(P)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op), .mask(mask),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .lane_flags(lane_flags), .z_all(z_all)
`ifdef VEC_REDUCE_EN
    , .red_sum(red_sum)
`endif
  );

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Lane semantics from signed/unsigned integer arithmetic in 64 bits.
  function automatic logic [35:0] ref_lane(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, s;
    logic [31:0] r;
    logic c, v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    c = 0;
    v = 0;
    case (o)
      3'd0: begin r = x + y; s = sx + sy; c = (64'(x) + 64'(y)) >= 64'h1_0000_0000; v = s > SMAX || s < SMIN; end
      3'd1: begin r = x - y; s = sx - sy; c = x >= y; v = s > SMAX || s < SMIN; end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = (sx < sy) ? x : y;
      3'd6: r = (sx > sy) ? x : y;
      default: r = y;
    endcase
    return {r[31], r == 0, c, v, r};
  endfunction

  task automatic model(input logic [2:0] o, input logic [L-1:0] m, input logic [VW-1:0] x, input logic [VW-1:0] y);
    logic [35:0] t;
    er = '0; ef = '0; es = '0;
    for (int i = 0; i < L; i++) begin
      t = ref_lane(o, x[i*W +: W], y[i*W +: W]);
      if (m[i]) begin
        er[i*W +: W] = t[31:0];
        ef[4*i +: 4] = t[35:32];
        es = es + t[31:0];
      end else er[i*W +: W] = x[i*W +: W];
    end
    ez = (er == '0);
  endtask

  task automatic send(input logic [2:0] o, input logic [L-1:0] m, input logic [VW-1:0] x, input logic [VW-1:0] y);
    @(negedge clk);
    op = o; mask = m; a = x; b = y; in_valid = 1;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    check("accept_ready", VW'(in_ready), VW'(1));
    @(negedge clk);
    in_valid = 0;
    op = 3'($urandom); mask = L'($urandom);
    for (int i = 0; i < L; i++) begin a[i*W +: W] = $urandom; b[i*W +: W] = $urandom; end
  endtask

  task automatic await_done(input string tag);
    repeat (K - 1) @(negedge clk);
    check({tag, "_early"}, VW'(out_valid), VW'(0));
    @(negedge clk);
    check({tag, "_valid"}, VW'(out_valid), VW'(1));
  endtask

  task automatic check_out(input string tag);
    check({tag, "_result"}, result, er);
    check({tag, "_flags"}, VW'(lane_flags), VW'(ef));
    check({tag, "_zall"}, VW'(z_all), VW'(ez));
    check({tag, "_inrdy"}, VW'(in_ready), VW'(0));
`ifdef VEC_REDUCE_EN
    check({tag, "_redsum"}, VW'(red_sum_w), VW'(es));
`endif
  endtask

  task automatic release_out(input string tag);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check({tag, "_drop"}, VW'({in_ready, out_valid}), VW'(2'b10));
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [L-1:0] m, input logic [VW-1:0] x, input logic [VW-1:0] y);
    model(o, m, x, y);
    send(o, m, x, y);
    await_done(tag);
    check_out(tag);
    release_out(tag);
  endtask

  task automatic fill(input logic [31:0] xa, input logic [31:0] xb);
    for (int i = 0; i < L; i++) begin va[i*W +: W] = xa; vb[i*W +: W] = xb; end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_inrdy"}, VW'(in_ready), VW'(1));
    check({tag, "_outv"}, VW'(out_valid), VW'(0));
    check({tag, "_result"}, result, '0);
    check({tag, "_flags"}, VW'(lane_flags), '0);
    check({tag, "_zall"}, VW'(z_all), VW'(1));
    check({tag, "_redsum"}, VW'(red_sum_w), '0);
  endtask

  initial begin
    logic [31:0] pick [5];
    pick = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    #2 reset = 1;
    #3;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < L; i++) begin va[i*W +: W] = i; vb[i*W +: W] = 32'h10; end
    run("add", 3'd0, 8'hFF, va, vb);
    check("add_lane5_lit", VW'(er[5*W +: W]), VW'(32'h15));
    check("add_flags_lit", VW'(ef), '0);

    fill(32'h12345678, 32'h9ABCDEF0);
    va[W-1:0] = 32'h80000000; vb[W-1:0] = 32'h1;
    va[2*W-1:W] = 32'h0;      vb[2*W-1:W] = 32'h1;
    run("sub", 3'd1, 8'hFF, va, vb);
    check("sub_l0_lit", VW'({ef[3:0], er[W-1:0]}), VW'({4'b0011, 32'h7FFFFFFF}));
    check("sub_l1_lit", VW'({ef[7:4], er[2*W-1:W]}), VW'({4'b1000, 32'hFFFFFFFF}));

    fill(32'hAAAAAAAA, 32'h55555555);
    run("mov_mask", 3'd7, 8'h0F, va, vb);
    check("mov_lit", er, {{4{32'hAAAAAAAA}}, {4{32'h55555555}}});
    check("mov_sum_lit", VW'(es), VW'(32'h55555554));

    fill(32'hFFFFFFFF, 32'h1);
    run("min", 3'd5, 8'hFF, va, vb);
    check("min_lit", er, {L{32'hFFFFFFFF}});
    run("max", 3'd6, 8'hFF, va, vb);
    check("max_lit", er, {L{32'h1}});
    fill(32'hF0, 32'h0F);
    run("and_zero", 3'd2, 8'hFF, va, vb);
    check("and_zall_lit", VW'({ez, ef}), VW'({1'b1, {L{4'b0100}}}));

    fill(32'h7FFFFFFF, 32'h1);
    model(3'd0, 8'hA5, va, vb);
    send(3'd0, 8'hA5, va, vb);
    await_done("bp");
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", result, er);
      check("bp_flags", VW'(lane_flags), VW'(ef));
      check("bp_state", VW'({in_ready, out_valid}), VW'(2'b01));
      @(negedge clk);
    end
    fill(32'h3, 32'h5);
    model(3'd4, 8'hFF, va, vb);
    op = 3'd4; mask = 8'hFF; a = va; b = vb; in_valid = 1; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("both_idle", VW'({in_ready, out_valid}), VW'(2'b10));
    @(negedge clk);
    in_valid = 0;
    check("both_accept", VW'(in_ready), VW'(0));
    await_done("both");
    check_out("both");
    release_out("both");

    fill(32'h11111111, 32'h22222222);
    send(3'd0, 8'hFF, va, vb);
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    #1;
    check_reset_vals("midreset");
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < L; i++) begin va[i*W +: W] = 32'h100 * i; vb[i*W +: W] = 32'h3; end
    run("after_reset", 3'd1, 8'hFF, va, vb);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < L; i++) begin
        va[i*W +: W] = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
        vb[i*W +: W] = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
      end
      run("rand", 3'($urandom_range(0, 7)), L'($urandom), va, vb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
